// File: rtl/poly_mul_sequencer_pkg.sv
// Shared types and constants for the NTRU-HRSS cyclic polynomial multiplier sequencer.
package poly_mul_sequencer_pkg;

    localparam int DEFAULT_N                = 701;
    localparam int DEFAULT_NUM_WIDTH_LENGTH = 13;
    localparam int DEFAULT_ADDR_W           = 10;

    // Ternary coefficient encoding: bit 0 = nonzero, bit 1 = negative (2'b10 reads as zero).
    localparam logic [1:0] R_ZERO = 2'b00;
    localparam logic [1:0] R_POS  = 2'b01;
    localparam logic [1:0] R_NEG  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH_R,
        LOAD_R,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/poly_mul_sequencer_arith.sv
// Ternary multiply-accumulate step: result = acc + r*coeff (mod 2^W), r in {-1, 0, +1}.
module poly_mul_sequencer_arith #(
    parameter int W = 13
) (
    input  logic         r,
    input  logic         r_next,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] coeff,
    output logic [W-1:0] result
);

    always_comb begin
        result = acc;
        if (r) begin
            result = r_next ? (acc - coeff) : (acc + coeff);
        end
    end

endmodule

// File: rtl/poly_mul_sequencer.sv
// Schoolbook sequencer computing e = r*h mod (x^N - 1) over external synchronous RAMs.
// Optional macro POLY_MUL_SKIP_ZERO_EN: skip the RUN/DRAIN pass for zero r coefficients.
module poly_mul_sequencer
    import poly_mul_sequencer_pkg::*;
#(
    parameter int N                = DEFAULT_N,
    parameter int NUM_WIDTH_LENGTH = DEFAULT_NUM_WIDTH_LENGTH,
    parameter int ADDR_W           = DEFAULT_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           r_addr,
    input  logic [1:0]                  r_rdata,
    output logic [ADDR_W-1:0]           h_addr,
    input  logic [NUM_WIDTH_LENGTH-1:0] h_rdata,
    output logic [ADDR_W-1:0]           e_raddr,
    input  logic [NUM_WIDTH_LENGTH-1:0] e_rdata,
    output logic [ADDR_W-1:0]           e_waddr,
    output logic [NUM_WIDTH_LENGTH-1:0] e_wdata,
    output logic                        e_we
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t state, state_n;

    logic [ADDR_W-1:0] i, i_n;
    logic [ADDR_W-1:0] k, k_n;
    logic [ADDR_W-1:0] k_d, k_d_n;
    logic [ADDR_W-1:0] j, j_n;
    logic [ADDR_W-1:0] j_start, j_start_n;
    logic              sel, sel_n;
    logic              neg, neg_n;
    logic              wb_valid, wb_n;

    // Address outputs show live values only while in use and otherwise replay these copies.
    logic [ADDR_W-1:0] r_addr_q, h_addr_q, e_raddr_q, e_waddr_q;

    logic                        r_nonzero;
    logic [NUM_WIDTH_LENGTH-1:0] au_result;

    assign r_nonzero = (r_rdata == R_POS) || (r_rdata == R_NEG);

    poly_mul_sequencer_arith #(
        .W(NUM_WIDTH_LENGTH)
    ) u_arith (
        .r      (sel),
        .r_next (neg),
        .acc    (e_rdata),
        .coeff  (h_rdata),
        .result (au_result)
    );

    always_comb begin
        state_n   = state;
        i_n       = i;
        k_n       = k;
        k_d_n     = k_d;
        j_n       = j;
        j_start_n = j_start;
        sel_n     = sel;
        neg_n     = neg;
        wb_n      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        e_we      = 1'b0;
        e_wdata   = '0;
        r_addr    = r_addr_q;
        h_addr    = h_addr_q;
        e_raddr   = e_raddr_q;
        e_waddr   = e_waddr_q;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_n   = CLEAR;
                    i_n       = '0;
                    k_n       = '0;
                    j_start_n = '0;
                end
            end
            CLEAR: begin
                e_we    = 1'b1;
                e_waddr = k;
                if (k == LAST) begin
                    k_n     = '0;
                    state_n = FETCH_R;
                end else begin
                    k_n = k + ONE;
                end
            end
            FETCH_R: begin
                r_addr  = i;
                state_n = LOAD_R;
            end
            LOAD_R: begin
                sel_n   = r_nonzero;
                neg_n   = (r_rdata == R_NEG);
                k_n     = '0;
                j_n     = j_start;
                state_n = RUN;
`ifdef POLY_MUL_SKIP_ZERO_EN
                // A zero coefficient contributes nothing, so advance straight to the next i.
                if (!r_nonzero) begin
                    j_start_n = (j_start == '0) ? LAST : (j_start - ONE);
                    if (i == LAST) begin
                        state_n = DONE;
                    end else begin
                        i_n     = i + ONE;
                        state_n = FETCH_R;
                    end
                end
`endif
            end
            RUN: begin
                e_raddr = k;
                h_addr  = j;
                k_d_n   = k;
                wb_n    = 1'b1;
                j_n     = (j == LAST) ? '0 : (j + ONE);
                // Write-back of the index read one cycle earlier; never collides with the read.
                if (wb_valid) begin
                    e_we    = 1'b1;
                    e_waddr = k_d;
                    e_wdata = au_result;
                end
                if (k == LAST) begin
                    k_n     = '0;
                    state_n = DRAIN;
                end else begin
                    k_n = k + ONE;
                end
            end
            DRAIN: begin
                e_we      = 1'b1;
                e_waddr   = k_d;
                e_wdata   = au_result;
                j_start_n = (j_start == '0) ? LAST : (j_start - ONE);
                if (i == LAST) begin
                    state_n = DONE;
                end else begin
                    i_n     = i + ONE;
                    state_n = FETCH_R;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            k         <= '0;
            k_d       <= '0;
            j         <= '0;
            j_start   <= '0;
            sel       <= 1'b0;
            neg       <= 1'b0;
            wb_valid  <= 1'b0;
            r_addr_q  <= '0;
            h_addr_q  <= '0;
            e_raddr_q <= '0;
            e_waddr_q <= '0;
        end else begin
            state     <= state_n;
            i         <= i_n;
            k         <= k_n;
            k_d       <= k_d_n;
            j         <= j_n;
            j_start   <= j_start_n;
            sel       <= sel_n;
            neg       <= neg_n;
            wb_valid  <= wb_n;
            r_addr_q  <= r_addr;
            h_addr_q  <= h_addr;
            e_raddr_q <= e_raddr;
            e_waddr_q <= e_waddr;
        end
    end

endmodule

// File: tb/tb_poly_mul_sequencer.sv
// Scoreboard bench for poly_mul_sequencer at N=5 with behavioural r/h/e RAMs.
// Cycle expectations follow POLY_MUL_SKIP_ZERO_EN when that macro is defined.
module tb_poly_mul_sequencer;
    import poly_mul_sequencer_pkg::*;

    localparam int NN = 5;
    localparam int W  = 13;
    localparam int AW = 10;

    typedef logic [0:NN-1][W-1:0] vec_t;
    typedef logic [0:NN-1][1:0]   rvec_t;
    typedef struct packed {
        vec_t        e;
        logic [15:0] cycles;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_rdata;
    logic [AW-1:0] h_addr;
    logic [W-1:0]  h_rdata;
    logic [AW-1:0] e_raddr;
    logic [W-1:0]  e_rdata;
    logic [AW-1:0] e_waddr;
    logic [W-1:0]  e_wdata;
    logic          e_we;

    logic [1:0]   r_mem [NN];
    logic [W-1:0] h_mem [NN];
    logic [W-1:0] e_mem [NN];

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   done_seen;
    int   runs_pushed;
    int   busy_cnt;

    poly_mul_sequencer #(
        .N                (NN),
        .NUM_WIDTH_LENGTH (W),
        .ADDR_W           (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .r_addr  (r_addr),
        .r_rdata (r_rdata),
        .h_addr  (h_addr),
        .h_rdata (h_rdata),
        .e_raddr (e_raddr),
        .e_rdata (e_rdata),
        .e_waddr (e_waddr),
        .e_wdata (e_wdata),
        .e_we    (e_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAMs with one-cycle read latency.
    always @(posedge clk) begin
        r_rdata <= r_mem[int'(r_addr) % NN];
        h_rdata <= h_mem[int'(h_addr) % NN];
        e_rdata <= e_mem[int'(e_raddr) % NN];
        if (e_we && (int'(e_waddr) < NN)) begin
            e_mem[int'(e_waddr)] <= e_wdata;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int expCycles(input rvec_t r);
        int c;
        c = NN + 1;
        for (int i = 0; i < NN; i++) begin
`ifdef POLY_MUL_SKIP_ZERO_EN
            c += r[i][0] ? (NN + 3) : 2;
`else
            c += NN + 3;
`endif
        end
        return c;
    endfunction

    // Loads the operand RAMs, optionally records the expected result, and pulses start.
    task automatic applyStimulus(input rvec_t r, input vec_t h, input vec_t e, input bit push);
        exp_t x;
        for (int i = 0; i < NN; i++) begin
            r_mem[i] = r[i];
            h_mem[i] = h[i];
        end
        if (push) begin
            x.e      = e;
            x.cycles = 16'(expCycles(r));
            exp_q.push_back(x);
            runs_pushed++;
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int n;
        n = 0;
        while ((done_seen < target) && (n < 200)) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_seen < target) begin
            checkOutput("done_timeout", done_seen, target);
        end
    endtask

    // Monitor: counts busy cycles and checks e against the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    for (int k = 0; k < NN; k++) begin
                        checkOutput($sformatf("e[%0d]", k), int'(e_mem[k]), int'(x.e[k]));
                    end
                    checkOutput("busy_cycles", busy_cnt, int'(x.cycles));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        vec_t  h_ramp, h_unit, h_big;
        vec_t  e_exp;
        rvec_t r_vec;
        checks      = 0;
        errors      = 0;
        done_seen   = 0;
        runs_pushed = 0;
        busy_cnt    = 0;
        rst   = 1'b1;
        start = 1'b0;
        h_ramp = '{13'd1, 13'd2, 13'd3, 13'd4, 13'd5};
        h_unit = '{13'd1, 13'd0, 13'd0, 13'd0, 13'd0};
        h_big  = '{13'd8191, 13'd8191, 13'd0, 13'd0, 13'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",    int'(busy),    0);
        checkOutput("rst_done",    int'(done),    0);
        checkOutput("rst_e_we",    int'(e_we),    0);
        checkOutput("rst_r_addr",  int'(r_addr),  0);
        checkOutput("rst_h_addr",  int'(h_addr),  0);
        checkOutput("rst_e_raddr", int'(e_raddr), 0);
        checkOutput("rst_e_waddr", int'(e_waddr), 0);
        checkOutput("rst_e_wdata", int'(e_wdata), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Identity multiplier.
        r_vec = '{R_POS, R_ZERO, R_ZERO, R_ZERO, R_ZERO};
        applyStimulus(r_vec, h_ramp, h_ramp, 1'b1);
        waitDone(1);

        // x * h rotates h by one; a second start mid-RUN must be ignored.
        r_vec = '{R_ZERO, R_POS, R_ZERO, R_ZERO, R_ZERO};
        e_exp = '{13'd5, 13'd1, 13'd2, 13'd3, 13'd4};
        applyStimulus(r_vec, h_ramp, e_exp, 1'b1);
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(2);

        // -x^2 * 1 gives 8191 at index 2.
        r_vec = '{R_ZERO, R_ZERO, R_NEG, R_ZERO, R_ZERO};
        e_exp = '{13'd0, 13'd0, 13'd8191, 13'd0, 13'd0};
        applyStimulus(r_vec, h_unit, e_exp, 1'b1);
        waitDone(3);

        // Mixed signs: e[k] = h[k] - h[k-1] + h[k+1].
        r_vec = '{R_POS, R_NEG, R_ZERO, R_ZERO, R_POS};
        e_exp = '{13'd8190, 13'd4, 13'd5, 13'd6, 13'd2};
        applyStimulus(r_vec, h_ramp, e_exp, 1'b1);
        waitDone(4);

        // Positive overflow wraps mod 8192; 2'b10 must act as zero.
        r_vec = '{R_POS, R_POS, 2'b10, R_ZERO, R_ZERO};
        e_exp = '{13'd8191, 13'd8190, 13'd8191, 13'd0, 13'd0};
        applyStimulus(r_vec, h_big, e_exp, 1'b1);
        waitDone(5);

        // Abort mid-RUN: no completion, outputs idle on the following cycle.
        r_vec = '{R_POS, R_NEG, R_ZERO, R_ZERO, R_POS};
        applyStimulus(r_vec, h_ramp, e_exp, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_e_we", int'(e_we), 0);
        checkOutput("abort_done", int'(done), 0);
        rst = 1'b0;

        // All-zero r after the abort: CLEAR must wipe the stale partial result.
        r_vec = '{R_ZERO, R_ZERO, R_ZERO, R_ZERO, R_ZERO};
        e_exp = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        applyStimulus(r_vec, h_ramp, e_exp, 1'b1);
        waitDone(6);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("done_count",  done_seen,     runs_pushed);
        checkOutput("queue_empty", exp_q.size(),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
